// File: rtl/lsu_addr_calc_pipe.sv
// LSU address calculator, pipelined. Captures one decoded memory instruction
// and streams its per-lane addresses out as beats of LANES_PER_BEAT lanes,
// skipping beats whose exec slice is empty.
module lsu_addr_calc_pipe #(
   parameter int NUM_LANES      = 64,
   parameter int LANES_PER_BEAT = 16,
   parameter int ADDR_W         = 32,
   localparam int NUM_BEATS     = NUM_LANES / LANES_PER_BEAT,
   localparam int BEAT_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [31:0]                      in_opcode,
   input  logic [NUM_LANES*32-1:0]          in_vector_source_a,
   input  logic [NUM_LANES*32-1:0]          in_vector_source_b,
   input  logic [127:0]                     in_scalar_source_a,
   input  logic [31:0]                      in_scalar_source_b,
   input  logic [15:0]                      in_lds_base,
   input  logic [15:0]                      in_imm_value0,
   input  logic [NUM_LANES-1:0]             in_exec,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES_PER_BEAT*ADDR_W-1:0] out_addr,
   output logic [LANES_PER_BEAT-1:0]        out_lane_mask,
   output logic [BEAT_W-1:0]                out_beat_idx,
   output logic                             out_last,
   output logic                             out_gm_or_lds,
   output logic                             out_illegal
);

   localparam int LANE_W = $clog2(NUM_LANES);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0]    lane_addr_d [NUM_LANES];
   logic [ADDR_W-1:0]    lane_addr_q [NUM_LANES];
   logic [NUM_LANES-1:0] exec_eff_d, exec_q;

   logic [LANES_PER_BEAT*ADDR_W-1:0] out_addr_q, beat_addr_d;
   logic [LANES_PER_BEAT-1:0]        out_lane_mask_q, beat_mask_d;
   logic [BEAT_W-1:0]                out_beat_idx_q, first_idx, next_idx, sel_idx;
   logic                             out_last_q, out_gm_or_lds_q, out_illegal_q;
   logic                             first_last, next_last, load_first, load_next;
   logic [BEAT_W:0]                  fb0, fb1, nb0, nb1;
   logic [LANE_W-1:0]                lane_sel;

   logic              is_smrd, is_ds, is_mtbuf, illegal_d;
   logic [ADDR_W-1:0] base, soff, stride, smrd_off, vsa, vsb, tid, idx_term, off_term;

   logic unused_bits;
   assign unused_bits = ^{in_scalar_source_a[127:120], in_scalar_source_a[118:62],
                          in_scalar_source_a[47:32], in_opcode[22:13], in_opcode[10:0]};

   // Lowest beat strictly above 'after' holding a set mask bit; MSB is the found flag.
   function automatic logic [BEAT_W:0] find_beat(input logic [NUM_LANES-1:0] m, input int after);
      logic [BEAT_W:0] r;
      r = '0;
      for (int l = NUM_LANES - 1; l >= 0; l--) begin
         if (m[l] && ((l / LANES_PER_BEAT) > after)) r = {1'b1, BEAT_W'(l / LANES_PER_BEAT)};
      end
      return r;
   endfunction

   assign is_smrd   = (in_opcode[31:24] == 8'h01);
   assign is_ds     = (in_opcode[31:24] == 8'h02);
   assign is_mtbuf  = (in_opcode[31:24] == 8'h04);
   assign illegal_d = !(is_smrd || is_ds || is_mtbuf);

   assign base     = ADDR_W'(in_scalar_source_a[31:0]);
   assign stride   = ADDR_W'(in_scalar_source_a[61:48]);
   assign soff     = ADDR_W'(in_scalar_source_b);
   assign smrd_off = in_opcode[23] ? (ADDR_W'(in_imm_value0) << 2) : soff;

   // Every lane's address from the live inputs; only used on the accept cycle.
   always_comb begin
      vsa      = '0;
      vsb      = '0;
      tid      = '0;
      idx_term = '0;
      off_term = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         vsa      = ADDR_W'(in_vector_source_a[l*32 +: 32]);
         vsb      = ADDR_W'(in_vector_source_b[l*32 +: 32]);
         tid      = in_scalar_source_a[119] ? ADDR_W'(l) : '0;
         idx_term = in_opcode[12] ? (vsa + tid) * stride : '0;
         off_term = in_opcode[11] ? vsb : '0;
         lane_addr_d[l] = '0;
         if (is_smrd) begin
            if (l == 0) lane_addr_d[l] = base + smrd_off;
         end else if (is_ds) begin
            lane_addr_d[l] = ADDR_W'(in_lds_base) + vsb;
         end else if (is_mtbuf) begin
            lane_addr_d[l] = base + soff + ADDR_W'(in_imm_value0[11:0]) + idx_term + off_term;
         end
      end
   end

   // Effective exec: SMRD forces lane 0 alone, illegal formats emit nothing active.
   always_comb begin
      exec_eff_d = '0;
      if (is_smrd)                exec_eff_d = NUM_LANES'(1);
      else if (is_ds || is_mtbuf) exec_eff_d = in_exec;
   end

   // First beat from live inputs and next beat from the captured mask, each with its last flag.
   always_comb begin
      fb0        = find_beat(exec_eff_d, -1);
      first_idx  = fb0[BEAT_W] ? fb0[BEAT_W-1:0] : '0;
      fb1        = find_beat(exec_eff_d, int'(first_idx));
      first_last = !fb1[BEAT_W];
      nb0        = find_beat(exec_q, int'(out_beat_idx_q));
      next_idx   = nb0[BEAT_W-1:0];
      nb1        = find_beat(exec_q, int'(next_idx));
      next_last  = !nb1[BEAT_W];
   end

   // Next-state and load strobes; a handshake is EMIT with out_ready.
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      load_next  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d    = EMIT;
               load_first = 1'b1;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (out_last_q) state_d = IDLE;
               else            load_next = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Gather the selected beat's addresses and mask from live or captured lanes.
   always_comb begin
      sel_idx     = load_first ? first_idx : next_idx;
      lane_sel    = '0;
      beat_addr_d = '0;
      beat_mask_d = '0;
      for (int j = 0; j < LANES_PER_BEAT; j++) begin
         lane_sel = LANE_W'(int'(sel_idx) * LANES_PER_BEAT + j);
         beat_addr_d[j*ADDR_W +: ADDR_W] = load_first ? lane_addr_d[lane_sel] : lane_addr_q[lane_sel];
         beat_mask_d[j] = load_first ? exec_eff_d[lane_sel] : exec_q[lane_sel];
      end
   end

   // Capture the whole instruction's lane addresses and mask at accept.
   always_ff @(posedge clk) begin
      if (load_first) begin
         lane_addr_q <= lane_addr_d;
         exec_q      <= exec_eff_d;
      end
   end

   // State and output beat register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         out_addr_q      <= '0;
         out_lane_mask_q <= '0;
         out_beat_idx_q  <= '0;
         out_last_q      <= 1'b0;
         out_gm_or_lds_q <= 1'b0;
         out_illegal_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_first || load_next) begin
            out_addr_q      <= beat_addr_d;
            out_lane_mask_q <= beat_mask_d;
            out_beat_idx_q  <= sel_idx;
            out_last_q      <= load_first ? first_last : next_last;
         end
         if (load_first) begin
            out_gm_or_lds_q <= is_ds;
            out_illegal_q   <= illegal_d;
         end
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == EMIT);
   assign out_addr      = out_addr_q;
   assign out_lane_mask = out_lane_mask_q;
   assign out_beat_idx  = out_beat_idx_q;
   assign out_last      = out_last_q;
   assign out_gm_or_lds = out_gm_or_lds_q;
   assign out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_lsu_addr_calc_pipe.sv
// Bench for lsu_addr_calc_pipe: directed and random instructions against a
// lane-by-lane reference model, with random and forced consumer backpressure.
module tb_lsu_addr_calc_pipe;
   localparam int NL  = 64;
   localparam int LPB = 16;
   localparam int AW  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [31:0]     in_opcode;
   logic [NL*32-1:0] in_vector_source_a, in_vector_source_b;
   logic [127:0]    in_scalar_source_a;
   logic [31:0]     in_scalar_source_b;
   logic [15:0]     in_lds_base, in_imm_value0;
   logic [NL-1:0]   in_exec;
   logic            out_valid, out_ready;
   logic [LPB*AW-1:0] out_addr;
   logic [LPB-1:0]  out_lane_mask;
   logic [1:0]      out_beat_idx;
   logic            out_last, out_gm_or_lds, out_illegal;

   lsu_addr_calc_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_vector_source_a(in_vector_source_a), .in_vector_source_b(in_vector_source_b),
      .in_scalar_source_a(in_scalar_source_a), .in_scalar_source_b(in_scalar_source_b),
      .in_lds_base(in_lds_base), .in_imm_value0(in_imm_value0), .in_exec(in_exec),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_lane_mask(out_lane_mask), .out_beat_idx(out_beat_idx), .out_last(out_last),
      .out_gm_or_lds(out_gm_or_lds), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // pending instruction
   logic [31:0]      p_op, p_sb;
   logic [NL*32-1:0] p_va, p_vb;
   logic [127:0]     p_sa;
   logic [15:0]      p_lds, p_imm;
   logic [NL-1:0]    p_ex;

   // expected beats
   logic [LPB*AW-1:0] q_addr[$];
   logic [LPB-1:0]    q_mask[$];
   int                q_idx[$];
   bit                q_last[$];
   bit                exp_lds, exp_ill;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: per-lane address from the format rules, then non-empty beats in order.
   task automatic model();
      logic [31:0]      a [NL];
      logic [NL-1:0]    m;
      logic [LPB*AW-1:0] ba;
      longint unsigned  base, stride, sum, va_k, vb_k;
      bit               any;
      base   = longint'(p_sa[31:0]);
      stride = longint'(p_sa[61:48]);
      m = '0;
      exp_lds = 1'b0;
      exp_ill = 1'b0;
      for (int k = 0; k < NL; k++) a[k] = 32'h0;
      case (p_op[31:24])
         8'h01: begin
            m[0] = 1'b1;
            sum  = base + (p_op[23] ? longint'(p_imm) * 4 : longint'(p_sb));
            a[0] = sum[31:0];
         end
         8'h02: begin
            m = p_ex;
            exp_lds = 1'b1;
            for (int k = 0; k < NL; k++) begin
               vb_k = longint'(p_vb[k*32 +: 32]);
               sum  = longint'(p_lds) + vb_k;
               a[k] = sum[31:0];
            end
         end
         8'h04: begin
            m = p_ex;
            for (int k = 0; k < NL; k++) begin
               va_k = longint'(p_va[k*32 +: 32]);
               vb_k = longint'(p_vb[k*32 +: 32]);
               sum  = base + longint'(p_sb) + longint'(p_imm[11:0]);
               if (p_op[12]) sum = sum + (va_k + (p_sa[119] ? longint'(k) : 0)) * stride;
               if (p_op[11]) sum = sum + vb_k;
               a[k] = sum[31:0];
            end
         end
         default: exp_ill = 1'b1;
      endcase
      any = 1'b0;
      for (int b = 0; b < NL / LPB; b++) begin
         if (m[b*LPB +: LPB] != '0) begin
            for (int j = 0; j < LPB; j++) ba[j*AW +: AW] = a[b*LPB + j];
            q_addr.push_back(ba);
            q_mask.push_back(m[b*LPB +: LPB]);
            q_idx.push_back(b);
            q_last.push_back(1'b0);
            any = 1'b1;
         end
      end
      if (!any) begin
         for (int j = 0; j < LPB; j++) ba[j*AW +: AW] = a[j];
         q_addr.push_back(ba);
         q_mask.push_back('0);
         q_idx.push_back(0);
         q_last.push_back(1'b0);
      end
      q_last[q_last.size() - 1] = 1'b1;
   endtask

   // Present the pending instruction for one edge; called at a negedge.
   task automatic send();
      model();
      in_opcode          = p_op;
      in_vector_source_a = p_va;
      in_vector_source_b = p_vb;
      in_scalar_source_a = p_sa;
      in_scalar_source_b = p_sb;
      in_lds_base        = p_lds;
      in_imm_value0      = p_imm;
      in_exec            = p_ex;
      in_valid           = 1'b1;
      check("accept_ready", 512'(in_ready), 512'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Drain expected beats; stall_after >= 0 forces 5 stalled cycles after that many handshakes.
   task automatic collect(input int stall_after);
      int   hs = 0, budget = 0, stall_cnt = 0;
      bit   holding = 1'b0, rdy;
      logic [LPB*AW-1:0] h_addr;
      logic [LPB-1:0]    h_mask;
      logic [1:0]        h_idx;
      logic [31:0]       r;
      while (q_addr.size() > 0 && budget < 300) begin
         budget++;
         check("no_bubble_valid", 512'(out_valid), 512'(1));
         check("busy_in_ready", 512'(in_ready), 512'(0));
         if (holding) begin
            check("hold_addr", 512'(out_addr), 512'(h_addr));
            check("hold_mask", 512'(out_lane_mask), 512'(h_mask));
            check("hold_idx", 512'(out_beat_idx), 512'(h_idx));
         end
         if (hs == stall_after && stall_cnt < 5) begin
            rdy = 1'b0;
            stall_cnt++;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         out_ready = rdy;
         r = $urandom();
         in_valid = r[0];
         in_opcode = $urandom();
         in_vector_source_b[31:0] = $urandom();
         in_exec = {$urandom(), $urandom()};
         if (rdy) begin
            check("beat_addr", 512'(out_addr), 512'(q_addr[0]));
            check("beat_mask", 512'(out_lane_mask), 512'(q_mask[0]));
            check("beat_idx", 512'(out_beat_idx), 512'(q_idx[0]));
            check("beat_last", 512'(out_last), 512'(q_last[0]));
            check("beat_lds", 512'(out_gm_or_lds), 512'(exp_lds));
            check("beat_illegal", 512'(out_illegal), 512'(exp_ill));
            void'(q_addr.pop_front());
            void'(q_mask.pop_front());
            void'(q_idx.pop_front());
            void'(q_last.pop_front());
            hs++;
            holding = 1'b0;
            if (q_addr.size() == 0) in_valid = 1'b0;
         end else begin
            holding = 1'b1;
            h_addr  = out_addr;
            h_mask  = out_lane_mask;
            h_idx   = out_beat_idx;
         end
         @(posedge clk);
         @(negedge clk);
      end
      check("drain_in_budget", 512'(budget < 300), 512'(1));
      check("done_valid", 512'(out_valid), 512'(0));
      check("done_in_ready", 512'(in_ready), 512'(1));
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   task automatic set_mtbuf_plan();
      p_op  = 32'h0400_1800;
      p_sa  = '0;
      p_sa[31:0]  = 32'h1000;
      p_sa[61:48] = 14'd16;
      p_sb  = 32'h20;
      p_imm = 16'd4;
      p_lds = 16'h0;
      for (int k = 0; k < NL; k++) begin
         p_va[k*32 +: 32] = k;
         p_vb[k*32 +: 32] = 32'd8;
      end
      p_ex = '1;
   endtask

   task automatic randomize_instr();
      logic [31:0] r;
      logic [7:0]  fmts [6];
      fmts = '{8'h01, 8'h02, 8'h04, 8'h04, 8'h08, 8'h00};
      r = $urandom();
      p_op = {fmts[$urandom_range(0, 5)], r[23:0]};
      for (int k = 0; k < NL; k++) begin
         p_va[k*32 +: 32] = $urandom();
         p_vb[k*32 +: 32] = $urandom();
      end
      p_sa  = {$urandom(), $urandom(), $urandom(), $urandom()};
      p_sb  = $urandom();
      r = $urandom();
      p_lds = r[15:0];
      p_imm = r[31:16];
      for (int b = 0; b < NL / LPB; b++) begin
         r = $urandom();
         p_ex[b*LPB +: LPB] = ($urandom_range(0, 2) == 0) ? 16'h0 : r[15:0];
      end
      if ($urandom_range(0, 7) == 0) p_ex = '0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_opcode = '0;
      in_vector_source_a = '0;
      in_vector_source_b = '0;
      in_scalar_source_a = '0;
      in_scalar_source_b = '0;
      in_lds_base = '0;
      in_imm_value0 = '0;
      in_exec = '0;
      #12;
      check("rst_in_ready", 512'(in_ready), 512'(1));
      check("rst_out_valid", 512'(out_valid), 512'(0));
      check("rst_out_addr", 512'(out_addr), 512'(0));
      check("rst_mask", 512'(out_lane_mask), 512'(0));
      check("rst_idx", 512'(out_beat_idx), 512'(0));
      check("rst_last", 512'(out_last), 512'(0));
      check("rst_lds", 512'(out_gm_or_lds), 512'(0));
      check("rst_illegal", 512'(out_illegal), 512'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // MTBUF idxen+offen, all lanes: four beats
      set_mtbuf_plan();
      send();
      check("mtbuf_lane5", 512'(out_addr[5*AW +: AW]), 512'(32'h107C));
      collect(-1);

      // DS with only beat 2 active
      p_op = 32'h0200_0000;
      p_lds = 16'h100;
      for (int k = 0; k < NL; k++) p_vb[k*32 +: 32] = 4 * k;
      p_ex = 64'h0000_FFFF_0000_0000;
      send();
      check("ds_lane0", 512'(out_addr[AW-1:0]), 512'(32'h180));
      collect(-1);

      // SMRD immediate
      p_op = 32'h0180_0000;
      p_imm = 16'd3;
      p_sa = '0;
      p_sa[31:0] = 32'h2000;
      p_ex = '0;
      send();
      check("smrd_lane0", 512'(out_addr[AW-1:0]), 512'(32'h200C));
      collect(-1);

      // backpressure mid-stream
      set_mtbuf_plan();
      send();
      collect(1);

      // illegal format
      p_op = 32'h0800_0000;
      send();
      collect(-1);

      // reset during beat 1 of 4
      set_mtbuf_plan();
      send();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("pre_rst_idx", 512'(out_beat_idx), 512'(1));
      rst = 1'b1;
      #1;
      check("midrst_valid", 512'(out_valid), 512'(0));
      check("midrst_idx", 512'(out_beat_idx), 512'(0));
      q_addr.delete();
      q_mask.delete();
      q_idx.delete();
      q_last.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_ready", 512'(in_ready), 512'(1));
      check("postrst_valid", 512'(out_valid), 512'(0));
      set_mtbuf_plan();
      send();
      collect(-1);

      // random instructions
      for (int n = 0; n < 40; n++) begin
         randomize_instr();
         send();
         collect((n % 5 == 0) ? 0 : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_addr_calc_pipe.md
Name: lsu_addr_calc_pipe

Overview:
- Parametrised, pipelined successor to the combinational LSU address calculator.
- Accepts one decoded memory instruction per handshake and captures its operands. Emits per-lane load/store addresses as a stream of beats, LANES_PER_BEAT lanes per beat.
- Supports MTBUF with idxen and offen both set: index and offset arrive on two separate VGPR read ports.
- Skips beats whose exec bits are all zero. Sits between the LSU operand-read stage and the LSU request generator.

Parameters:
NUM_LANES, 64, wavefront width; power of two.
LANES_PER_BEAT, 16, lanes emitted per output beat; power of two, divides NUM_LANES.
ADDR_W, 32, per-lane address width.
NUM_BEATS, NUM_LANES/LANES_PER_BEAT, derived; not overridable.
BEAT_W, max(1,clog2(NUM_BEATS)), derived beat-index width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  instruction present
in_ready  output  1  block can accept an instruction
in_opcode  input  32  [31:24] format (01 SMRD, 02 DS, 04 MTBUF); [23] SMRD imm; [12] idxen; [11] offen
in_vector_source_a  input  NUM_LANES*32  MTBUF per-lane index VGPR
in_vector_source_b  input  NUM_LANES*32  per-lane offset/address VGPR
in_scalar_source_a  input  128  resource descriptor; [47:0] base, [61:48] stride, [119] add_tid_enable
in_scalar_source_b  input  32  scalar offset
in_lds_base  input  16  LDS allocation base
in_imm_value0  input  16  immediate offset
in_exec  input  NUM_LANES  lane exec mask
out_valid  output  1  beat present
out_ready  input  1  consumer accepts beat
out_addr  output  LANES_PER_BEAT*ADDR_W  lane addresses; lane j of beat b is global lane b*LANES_PER_BEAT+j
out_lane_mask  output  LANES_PER_BEAT  exec bits for this beat
out_beat_idx  output  BEAT_W  beat number
out_last  output  1  final beat of instruction
out_gm_or_lds  output  1  1 = LDS, 0 = global memory
out_illegal  output  1  unsupported format

Behaviour:
- Reset (asynchronous, any state): state IDLE. Outputs: in_ready=1, out_valid=0, out_addr=0, out_lane_mask=0, out_beat_idx=0, out_last=0, out_gm_or_lds=0, out_illegal=0. Reset mid-instruction discards it; no further beats are emitted.
- FSM states IDLE, EMIT.
- IDLE: in_ready=1. On in_valid, capture all inputs and enter EMIT. The first beat is registered, so out_valid=1 the next cycle (latency 1).
- EMIT: in_ready=0.
  - The current beat holds stable while out_valid && !out_ready.
  - On handshake with out_last=0: load the next beat with a nonzero exec slice, in the following cycle (no bubble).
  - On handshake with out_last=1: return to IDLE; out_valid=0 the next cycle. Back-to-back accept therefore costs one idle cycle.
- Beat selection:
  - Only beats with a nonzero exec slice are emitted, in ascending order. out_last marks the highest such beat.
  - All-zero exec: one beat, index 0, mask 0, out_last=1.
  - SMRD: exactly one beat, index 0; lane 0 valid, mask bit0=1, other lanes 0, exec ignored.
- Address arithmetic: all modulo 2^ADDR_W; tid = global lane number when add_tid_enable=1, else 0.
  - SMRD: base[31:0] + (imm ? imm_value0*4 : scalar_source_b). out_gm_or_lds=0.
  - DS: zero-extended in_lds_base + vector_source_b lane. out_gm_or_lds=1.
  - MTBUF: base[31:0] + scalar_source_b + imm_value0[11:0] + (idxen ? (vector_source_a lane + tid)*stride : 0) + (offen ? vector_source_b lane : 0). out_gm_or_lds=0. idxen=offen=1 is legal.
  - Other formats: one beat, out_addr=0, mask 0, out_last=1, out_illegal=1.
- out_illegal and out_gm_or_lds are constant across all beats of an instruction.
- Inactive lanes within an emitted beat still carry computed addresses; consumers use the mask.
- in_valid while in_ready=0 is ignored and not captured.

Test Plan:
- MTBUF, idxen=1 offen=1, base=0x1000, stride=16, soffset=0x20, imm=4, idx lane k=k, off lane k=8, tid off, exec all ones -> 4 beats, indices 0..3; lane k addr = 0x102C+16k; out_last only on beat 3.
- DS, lds_base=0x100, vaddr lane k=4k, exec=0x0000_FFFF_0000_0000 -> single beat, index 2, lane j addr = 0x100+4*(32+j), out_last=1, out_gm_or_lds=1.
- SMRD, imm=1, imm_value0=3, base=0x2000 -> one beat, addr lane0=0x200C, mask=0x0001, out_last=1.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> beat and address unchanged; no beat dropped or duplicated; in_ready stays 0.
- Opcode format 0x08 -> one beat, out_illegal=1, mask 0; then IDLE with in_ready=1.
- Reset asserted during beat 1 of 4 -> out_valid=0 immediately; in_ready=1 after release; next instruction starts at beat 0.
